ram_sync_clr: RTL and testbench
===============================

// Module: ram_sync_clr
// PURPOSE
//   Writable companion to the team's ROM: 2**ADDR_W-word x DATA_W-bit single-port-array RAM.
//   Separate write and read ports; both synchronous to clk.
//   After reset or a clr request, a built-in sweep FSM fills every word with CLR_VAL before accepting traffic.
//   Sits where tables must be loaded at run time rather than from a .mem file.
// PARAMETERS
//   ADDR_W   3              address width; depth = 2**ADDR_W words
//   DATA_W   2              word width in bits
//   CLR_VAL  '0 (DATA_W b)  value written to every word during a clear sweep
// PORTS
//   clk       in   1       single clock, rising edge
//   reset     in   1       asynchronous, active-high reset
//   clr       in   1       synchronous request to re-run the clear sweep
//   we        in   1       write request
//   wa        in   ADDR_W  write address
//   wd        in   DATA_W  write data
//   w_ready   out  1       1 = writes are accepted this cycle
//   re        in   1       read request
//   ra        in   ADDR_W  read address
//   rd        out  DATA_W  read data
//   rd_valid  out  1       rd holds data for the read accepted on the previous edge
//   busy      out  1       1 while the clear sweep runs
// BEHAVIOUR
//   Reset (async, active-high):
//     - state=CLEAR, sweep counter=0, busy=1, w_ready=0, rd_valid=0, rd='0.
//     - Memory contents are not reset directly; the sweep overwrites them.
//   CLEAR state:
//     - Each edge writes CLR_VAL to mem[cnt] and increments cnt.
//     - Exactly 2**ADDR_W cycles; the edge that writes the last word (cnt=2**ADDR_W-1) moves to RUN.
//     - busy=1 and w_ready=0 throughout; we, re and clr are ignored (rd_valid stays 0).
//   RUN state:
//     - busy=0, w_ready=1.
//     - Write: we=1 -> mem[wa]<=wd at that edge; visible to reads from the next edge on.
//     - Read:
//       - re=1 at edge N -> rd=mem[ra] and rd_valid=1 after edge N (latency 1); rd_valid is a 1-cycle pulse per accepted read.
//       - re=0 -> rd_valid=0 and rd holds its last value.
//     - Read and write to the same address on the same edge: read-first; rd returns the old word.
//     - clr=1 at an edge: state->CLEAR, cnt->0, busy=1 after that edge.
//       - A we on that same edge is dropped (clr wins).
//       - A re on that same edge is still served (rd_valid=1 next cycle).
//   Reset mid-sweep or mid-run restarts the sweep from cnt=0; any in-flight rd_valid is forced to 0.
//   Addresses are full-range; no out-of-range case exists. The counter is ADDR_W+1 bits wide, so the sweep ends without wrap ambiguity.
// STRUCTURE
//   Package ram_pkg:
//     - typedef enum logic {CLEAR, RUN} ram_state_t
//     - localparam function for depth
//   Sub-module ram_core(clk, we, wa, wd, ra, rd_raw):
//     - plain synchronous array, read-first, no reset.
//     - Top level muxes the sweep address/data into its write port and owns the FSM, rd_valid and rd hold.
// TESTING (ADDR_W=3, DATA_W=2, CLR_VAL=0)
//   1. Pulse reset, then issue re each cycle -> busy=1 for exactly 8 cycles, no rd_valid; then reads of addr 0..7 -> rd=2'b00 each.
//   2. In RUN: we, wa=5, wd=2'b11; next cycle re, ra=5 -> one cycle later rd=2'b11, rd_valid=1 for one cycle.
//   3. mem[2]=2'b01, then same edge we wa=2 wd=2'b10 and re ra=2 -> rd=2'b01; following read of 2 -> 2'b10.
//   4. Fill all words with 2'b11; assert clr with we wa=0 wd=2'b01 -> 8 busy cycles; afterwards every word reads 2'b00 (write dropped).
//   5. Assert reset at sweep cycle 4, release -> busy lasts a full 8 further cycles, rd_valid=0, rd=0.
//   6. During CLEAR: we wa=1 wd=2'b10 -> ignored (w_ready=0); after sweep, addr 1 reads 2'b00.

Source files
------------

// File: rtl/ram_sync_clr_pkg.sv
// Shared types and helpers for the run-time-loadable RAM with clear sweep.
package ram_pkg;

    // CLEAR: sweep is filling every word with the clear value; RUN: normal traffic.
    typedef enum logic {CLEAR, RUN} ram_state_t;

    // Number of words addressed by an address bus of the given width.
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/ram_sync_clr_if.sv
// Write/read/clear bus of ram_sync_clr. master drives requests, slave answers.
interface ram_sync_clr_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 2
);
    import ram_pkg::*;

    logic              clr;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              w_ready;
    logic              re;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rd_valid;
    logic              busy;

    modport master (
        output clr, we, wa, wd, re, ra,
        input  w_ready, rd, rd_valid, busy
    );

    modport slave (
        input  clr, we, wa, wd, re, ra,
        output w_ready, rd, rd_valid, busy
    );

endinterface

// File: rtl/ram_sync_clr_core.sv
// Plain synchronous storage array: one write port, one registered read port.
// A read and a write to the same word on the same edge return the old word.
module ram_core
    import ram_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] rd_raw
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write and registered read share the edge; the read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        rd_raw <= mem[ra];
    end

endmodule

// File: rtl/ram_sync_clr.sv
// RAM that clears itself after reset or on request, then serves
// independent write and read traffic with one cycle of read latency.
module ram_sync_clr
    import ram_pkg::*;
#(
    parameter int              ADDR_W  = 3,
    parameter int              DATA_W  = 2,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    ram_sync_clr_if.slave bus
);

    localparam int              DEPTH    = depth_of(ADDR_W);
    // Counter is one bit wider than the address so the last sweep word is unambiguous.
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    ram_state_t        state_reg, state_next;
    logic [ADDR_W:0]   cnt_reg, cnt_next;
    logic              rd_valid_reg, rd_valid_next;
    logic [DATA_W-1:0] rd_hold_reg;
    logic [DATA_W-1:0] rd_raw;

    logic              core_we;
    logic [ADDR_W-1:0] core_wa;
    logic [DATA_W-1:0] core_wd;

    ram_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_core (
        .clk    (clk),
        .we     (core_we),
        .wa     (core_wa),
        .wd     (core_wd),
        .ra     (bus.ra),
        .rd_raw (rd_raw)
    );

    // State, sweep counter, read-valid pulse and the held copy of the last read word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= CLEAR;
            cnt_reg      <= '0;
            rd_valid_reg <= 1'b0;
            rd_hold_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            rd_valid_reg <= rd_valid_next;
            if (rd_valid_reg) begin
                rd_hold_reg <= rd_raw;
            end
        end
    end

    // Next state and write-port steering: the sweep owns the write port while clearing.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        rd_valid_next = 1'b0;
        core_we       = 1'b0;
        core_wa       = bus.wa;
        core_wd       = bus.wd;
        case (state_reg)
            CLEAR: begin
                core_we  = 1'b1;
                core_wa  = cnt_reg[ADDR_W-1:0];
                core_wd  = CLR_VAL;
                cnt_next = cnt_reg + (ADDR_W + 1)'(1);
                if (cnt_reg == LAST_CNT) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // A read on the clr edge is still served; a write on it is dropped.
                rd_valid_next = bus.re;
                core_we       = bus.we & ~bus.clr;
                if (bus.clr) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    assign bus.busy     = (state_reg == CLEAR);
    assign bus.w_ready  = (state_reg == RUN);
    assign bus.rd_valid = rd_valid_reg;
    // Fresh word in the cycle after an accepted read, otherwise the last word read.
    assign bus.rd       = rd_valid_reg ? rd_raw : rd_hold_reg;

endmodule

// File: tb/tb_ram_sync_clr.sv
// Randomized and directed stimulus for ram_sync_clr, checked against a
// word-array reference model that treats a clear as "unavailable for N
// cycles, then every word equals the clear value".
module tb_ram_sync_clr;

    localparam int         AW    = 3;
    localparam int         DW    = 2;
    localparam int         DEPTH = 1 << AW;
    localparam logic [1:0] CLRV  = 2'b00;

    logic clk;
    logic reset;

    ram_sync_clr_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_sync_clr #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .CLR_VAL (CLRV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [DW-1:0] model_mem [DEPTH];
    int            busy_left;
    logic [DW-1:0] exp_rd;
    logic          exp_rd_valid;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Compare all outputs with the model (called away from the clock edge).
    task automatic check_outputs(input string ctx);
        check({ctx, ".busy"},     32'(bus.busy),     32'(busy_left > 0));
        check({ctx, ".w_ready"},  32'(bus.w_ready),  32'(busy_left == 0));
        check({ctx, ".rd_valid"}, 32'(bus.rd_valid), 32'(exp_rd_valid));
        check({ctx, ".rd"},       32'(bus.rd),       32'(exp_rd));
    endtask

    // One clock cycle with the given request; model updated from the rules, then checked.
    task automatic step(input logic c, input logic w, input logic [AW-1:0] a_w,
                        input logic [DW-1:0] d_w, input logic r, input logic [AW-1:0] a_r);
        bus.clr = c;
        bus.we  = w;
        bus.wa  = a_w;
        bus.wd  = d_w;
        bus.re  = r;
        bus.ra  = a_r;
        @(posedge clk);
        if (busy_left > 0) begin
            busy_left--;
            exp_rd_valid = 1'b0;
            if (busy_left == 0) begin
                for (int i = 0; i < DEPTH; i++) model_mem[i] = CLRV;
            end
        end else begin
            exp_rd_valid = r;
            if (r) exp_rd = model_mem[a_r];
            if (c) busy_left = DEPTH;
            else if (w) model_mem[a_w] = d_w;
        end
        #1;
        check_outputs("step");
        $display("txn t=%0t clr=%0b we=%0b wa=%0d wd=%0d re=%0b ra=%0d -> busy=%0b rdv=%0b rd=%0d",
                 $time, c, w, a_w, d_w, r, a_r, bus.busy, bus.rd_valid, bus.rd);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic rd_addr(input logic [AW-1:0] a);
        step(1'b0, 1'b0, '0, '0, 1'b1, a);
    endtask

    task automatic wr_addr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step(1'b0, 1'b1, a, d, 1'b0, '0);
    endtask

    // Asynchronous reset: outputs must drop immediately, held across one edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        busy_left    = DEPTH;
        exp_rd       = '0;
        exp_rd_valid = 1'b0;
        check("rst.busy",     32'(bus.busy),     32'd1);
        check("rst.w_ready",  32'(bus.w_ready),  32'd0);
        check("rst.rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst.rd",       32'(bus.rd),       32'd0);
        $display("txn t=%0t reset asserted -> busy=%0b rdv=%0b rd=%0d",
                 $time, bus.busy, bus.rd_valid, bus.rd);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        bus.clr = 1'b0;
        bus.we  = 1'b0;
        bus.wa  = '0;
        bus.wd  = '0;
        bus.re  = 1'b0;
        bus.ra  = '0;
        busy_left    = DEPTH;
        exp_rd       = '0;
        exp_rd_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = CLRV;
        @(posedge clk);
        #1;

        // 1: reset, reads during the sweep are ignored, then every word is clear.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, '0, '0, 1'b1, AW'($urandom_range(0, DEPTH - 1)));
        for (int i = 0; i < DEPTH; i++) rd_addr(AW'(i));
        idle();

        // 2: write then read back one word; rd_valid pulses once.
        wr_addr(3'd5, 2'b11);
        rd_addr(3'd5);
        idle();
        idle();

        // 3: same-edge read and write return the old word.
        wr_addr(3'd2, 2'b01);
        step(1'b0, 1'b1, 3'd2, 2'b10, 1'b1, 3'd2);
        rd_addr(3'd2);
        idle();

        // 4: fill, then clr with a simultaneous write that must be dropped.
        for (int i = 0; i < DEPTH; i++) wr_addr(AW'(i), 2'b11);
        step(1'b1, 1'b1, 3'd0, 2'b01, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) idle();
        for (int i = 0; i < DEPTH; i++) rd_addr(AW'(i));
        idle();

        // 5: reset in the middle of a sweep restarts it from the beginning.
        for (int i = 0; i < DEPTH; i++) wr_addr(AW'(i), AW'(i) & 2'b11 | 2'b01);
        rd_addr(3'd3);
        step(1'b1, 1'b0, '0, '0, 1'b1, 3'd6);
        for (int i = 0; i < 4; i++) idle();
        do_reset();

        // 6: write during the sweep is ignored.
        step(1'b0, 1'b1, 3'd1, 2'b10, 1'b0, '0);
        for (int i = 1; i < DEPTH; i++) idle();
        rd_addr(3'd1);
        idle();

        // Random traffic with occasional clears.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, DEPTH - 1)),
                 DW'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, DEPTH - 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
